// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/LCD sync generator with pixel request and test-pattern mux.
// Pixel request is combinational off the counters; sync/de/rgb are registered one cycle later.
module vga_timing_gen #(
  parameter int CNT_W = 12,
  parameter int DATA_W = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 40,
  parameter int H_LEFT = 8,
  parameter int H_VALID = 640,
  parameter int H_RIGHT = 8,
  parameter int H_FRONT = 8,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 25,
  parameter int V_TOP = 8,
  parameter int V_VALID = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT = 2,
  parameter logic H_POL = 1'b1,
  parameter logic V_POL = 1'b1,
  parameter int REQ_LEAD = 1,
  parameter logic [DATA_W-1:0] BORDER_RGB = '0
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_data_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [DATA_W-1:0] rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA = H_SYNC + H_BACK + H_LEFT;
  localparam int VA = V_SYNC + V_BACK + V_TOP;
  localparam logic [CNT_W-1:0] C_HT1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_VT1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_HA = CNT_W'(HA);
  localparam logic [CNT_W-1:0] C_HAE = CNT_W'(HA + H_VALID - 1);
  localparam logic [CNT_W-1:0] C_VA = CNT_W'(VA);
  localparam logic [CNT_W-1:0] C_VAE = CNT_W'(VA + V_VALID - 1);
  localparam logic [CNT_W-1:0] C_HB = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] C_HBE = CNT_W'(HA + H_VALID + H_RIGHT - 1);
  localparam logic [CNT_W-1:0] C_VB = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] C_VBE = CNT_W'(VA + V_VALID + V_BOTTOM - 1);
  localparam logic [CNT_W-1:0] C_RS = CNT_W'(HA - REQ_LEAD);
  localparam logic [CNT_W-1:0] C_RE = CNT_W'(HA + H_VALID - 1 - REQ_LEAD);
  localparam logic [CNT_W-1:0] C_HS = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_VS = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] C_BW = CNT_W'(H_VALID / 8);
  localparam logic [DATA_W-1:0] BARS [8] = '{
    DATA_W'(16'hFFFF), DATA_W'(16'hFFE0), DATA_W'(16'h07FF), DATA_W'(16'h07E0),
    DATA_W'(16'hF81F), DATA_W'(16'hF800), DATA_W'(16'h001F), DATA_W'(16'h0000)
  };

  if (H_TOTAL >= 2**CNT_W || V_TOTAL >= 2**CNT_W || REQ_LEAD < 0 || REQ_LEAD > HA || H_VALID % 8 != 0) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [CNT_W-1:0]  r_cnt_h, r_cnt_v, w_col, w_row;
  logic [1:0]        r_mode_q;
  logic [DATA_W-1:0] r_rgb, w_pix, w_rgb;
  logic [2:0]        w_bar;
  logic              r_de, r_hsync, r_vsync, r_fs;
  logic              w_h_act, w_v_act, w_act, w_bdr, w_req, w_origin;

  assign w_h_act = r_cnt_h >= C_HA && r_cnt_h <= C_HAE;
  assign w_v_act = r_cnt_v >= C_VA && r_cnt_v <= C_VAE;
  assign w_act = w_h_act && w_v_act;
  assign w_bdr = r_cnt_h >= C_HB && r_cnt_h <= C_HBE && r_cnt_v >= C_VB && r_cnt_v <= C_VBE;
  assign w_origin = r_cnt_h == '0 && r_cnt_v == '0;
  assign w_col = r_cnt_h - C_HA;
  assign w_row = r_cnt_v - C_VA;
  assign w_bar = 3'(w_col / C_BW);
  // Pattern choice uses the frame-latched mode so a mid-frame switch never tears.
  assign w_pix = r_mode_q == 2'd0 ? pix_data :
                 r_mode_q == 2'd1 ? BARS[w_bar] :
                 r_mode_q == 2'd2 ? {DATA_W{~(w_col[5] ^ w_row[5])}} : BORDER_RGB;
  assign w_rgb = w_act ? w_pix : w_bdr ? BORDER_RGB : '0;
  assign w_req = r_cnt_h >= C_RS && r_cnt_h <= C_RE && w_v_act;
  assign pix_data_req = w_req;
  assign pix_x = w_req ? r_cnt_h - C_RS : '1;
  assign pix_y = w_req ? w_row : '1;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
      r_mode_q <= '0;
      r_rgb <= '0;
      r_de <= 1'b0;
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_fs <= 1'b0;
    end else if (en) begin
      r_cnt_h <= r_cnt_h == C_HT1 ? '0 : r_cnt_h + 1'b1;
      if (r_cnt_h == C_HT1) r_cnt_v <= r_cnt_v == C_VT1 ? '0 : r_cnt_v + 1'b1;
      if (w_origin) r_mode_q <= mode;
      r_rgb <= w_rgb;
      r_de <= w_act;
      r_hsync <= r_cnt_h < C_HS ? H_POL : ~H_POL;
      r_vsync <= r_cnt_v < C_VS ? V_POL : ~V_POL;
      r_fs <= w_origin;
    end else begin
      r_rgb <= '0;
      r_de <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign rgb = r_rgb;
  assign de = r_de;
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two reduced-geometry instances (active-high/lead 1, active-low/lead 0)
// checked every cycle against a frame-position model, plus literal frame statistics.
module tb_vga_timing_gen;
  localparam int HS = 4, HBK = 3, HL = 2, HV = 64, HR = 2, HF = 3;
  localparam int VS = 2, VBK = 2, VT = 1, VV = 40, VB = 1, VF = 2;
  localparam int HT = HS + HBK + HL + HV + HR + HF;
  localparam int VTOT = VS + VBK + VT + VV + VB + VF;
  localparam int HA = HS + HBK + HL;
  localparam int VA = VS + VBK + VT;
  localparam int FRAME = HT * VTOT;
  localparam logic [15:0] BORDER = 16'h1234;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, use_coord = 1'b1, chk_on = 1'b0, cnt_on = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] pd = '0;
  logic a_req, a_de, a_hs, a_vs, a_fs, b_req, b_de, b_hs, b_vs, b_fs;
  logic [11:0] a_x, a_y, b_x, b_y, cx, cy;
  logic [15:0] a_rgb, b_rgb;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int total = 0, bad = 0;
  int pos = 0;
  logic [1:0] mq = '0;
  logic m_de = 0, m_hsf = 0, m_vsf = 0, m_fs = 0;
  logic [15:0] m_rgb = '0;
  int n_hs, n_vs, n_de, n_req, n_fs, idx, first_a, first_b;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_SYNC(HS), .H_BACK(HBK), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VBK), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VB), .V_FRONT(VF),
    .H_POL(1'b1), .V_POL(1'b1), .REQ_LEAD(1), .BORDER_RGB(BORDER)) dut_a (
    .vga_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .pix_data(pd), .pix_data_req(a_req),
    .pix_x(a_x), .pix_y(a_y), .rgb(a_rgb), .de(a_de), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs));

  vga_timing_gen #(.H_SYNC(HS), .H_BACK(HBK), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VBK), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VB), .V_FRONT(VF),
    .H_POL(1'b0), .V_POL(1'b0), .REQ_LEAD(0), .BORDER_RGB(BORDER)) dut_b (
    .vga_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .pix_data(pd), .pix_data_req(b_req),
    .pix_x(b_x), .pix_y(b_y), .rgb(b_rgb), .de(b_de), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs));

  function automatic bit in_act(int h, int v);
    return h >= HA && h < HA + HV && v >= VA && v < VA + VV;
  endfunction

  function automatic logic [15:0] exp_rgb(int h, int v, int m, logic [15:0] d);
    int x = h - HA, y = v - VA;
    if (in_act(h, v)) begin
      if (m == 0) return d;
      if (m == 1) return bars[x / (HV / 8)];
      if (m == 2) return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'h0000 : 16'hFFFF;
      return BORDER;
    end
    if (h >= HS + HBK && h < HA + HV + HR && v >= VS + VBK && v < VA + VV + VB) return BORDER;
    return 16'h0000;
  endfunction

  function automatic logic [44:0] exp_vec(logic pol, int lead);
    int h = pos % HT, v = pos / HT;
    logic r;
    r = h >= HA - lead && h <= HA + HV - 1 - lead && v >= VA && v < VA + VV;
    return {m_de, m_rgb, pol ? m_hsf : !m_hsf, pol ? m_vsf : !m_vsf, m_fs, r,
            r ? 12'(h - (HA - lead)) : 12'hFFF, r ? 12'(v - VA) : 12'hFFF};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Model: a single enabled-cycle position within the frame drives every expectation.
  always @(posedge clk) begin
    if (rst) begin
      pos <= 0; mq <= '0; m_de <= 0; m_rgb <= '0; m_hsf <= 0; m_vsf <= 0; m_fs <= 0;
    end else if (en) begin
      m_de <= in_act(pos % HT, pos / HT);
      m_rgb <= exp_rgb(pos % HT, pos / HT, int'(mq), pd);
      m_hsf <= pos % HT < HS;
      m_vsf <= pos / HT < VS;
      m_fs <= pos == 0;
      if (pos == 0) mq <= mode;
      pos <= (pos + 1) % FRAME;
    end else begin
      m_de <= 0; m_rgb <= '0; m_fs <= 0;
    end
  end

  always @(negedge clk) begin
    logic [44:0] va;
    va = exp_vec(1'b1, 1);
    {cx, cy} = va[23:0];
    if (chk_on) begin
      check("dut_a", {a_de, a_rgb, a_hs, a_vs, a_fs, a_req, a_x, a_y}, va);
      check("dut_b", {b_de, b_rgb, b_hs, b_vs, b_fs, b_req, b_x, b_y}, exp_vec(1'b0, 0));
    end
    if (cnt_on) begin
      n_hs += int'(a_hs); n_vs += int'(a_vs); n_de += int'(a_de); n_req += int'(a_req); n_fs += int'(a_fs);
      if (a_req && first_a < 0) first_a = idx;
      if (b_req && first_b < 0) first_b = idx;
      idx++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pd = use_coord ? {cy[5:0], cx[9:0]} : 16'($urandom);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 3 * FRAME && !a_fs; i++) step();
    check("wait_fs", a_fs, 1);
  endtask

  task automatic measure(input int gap, input bit full);
    wait_fs();
    n_hs = 0; n_vs = 0; n_de = 0; n_req = 0; n_fs = 0; idx = 0; first_a = -1; first_b = -1;
    cnt_on = 1;
    for (int i = 0; i < FRAME + gap; i++) begin
      en = !(i >= 600 && i < 600 + gap);
      step();
    end
    cnt_on = 0;
    en = 1;
    check("cnt_hsync", n_hs, HS * VTOT);
    check("cnt_vsync", n_vs, VS * HT);
    check("cnt_de", n_de, HV * VV);
    check("cnt_fs", n_fs, 1);
    if (full) begin
      check("cnt_req", n_req, HV * VV);
      check("first_req_a", first_a, VA * HT + HA - 1 - 1);
      check("first_req_b", first_b, VA * HT + HA - 1);
    end
  endtask

  initial begin
    int gap;
    check("pin_bar0", exp_rgb(HA, VA, 1, 16'h0), 16'hFFFF);
    check("pin_bar1", exp_rgb(HA + 8, VA, 1, 16'h0), 16'hFFE0);
    check("pin_bar7", exp_rgb(HA + 63, VA + 39, 1, 16'h0), 16'h0000);
    check("pin_chk_r0c32", exp_rgb(HA + 32, VA, 2, 16'h0), 16'h0000);
    check("pin_chk_r32c32", exp_rgb(HA + 32, VA + 32, 2, 16'h0), 16'hFFFF);
    check("pin_border", exp_rgb(HA - 1, VA, 0, 16'h5555), 16'h1234);
    check("pin_blank", exp_rgb(HA - 3, VA, 0, 16'h5555), 16'h0000);
    check("pin_pass", exp_rgb(HA, VA, 0, 16'hBEEF), 16'hBEEF);
    step();
    chk_on = 1;
    check("rst_de", a_de, 0);
    check("rst_hs_a", a_hs, 0);
    check("rst_hs_b", b_hs, 1);
    check("rst_vs_b", b_vs, 1);
    en = 1;
    step(); step();
    rst = 0;
    step();
    check("fs_first", a_fs, 1);
    check("hs_sync_b", b_hs, 0);
    step();
    check("fs_once", a_fs, 0);
    measure(0, 1);
    measure(50, 0);
    mode = 2'd1;
    wait_fs();
    for (int i = 0; i < FRAME + 20 * HT; i++) step();
    mode = 2'd2;
    for (int i = 0; i < 2 * FRAME; i++) step();
    use_coord = 0;
    gap = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 499) == 0) gap = $urandom_range(1, 60);
      en = gap == 0;
      if ($urandom_range(0, 699) == 0) mode = 2'($urandom);
      rst = $urandom_range(0, 4999) == 0;
      step();
    end
    rst = 0; en = 1;
    for (int i = 0; i < 2 * FRAME && pos != 30 * HT; i++) step();
    check("reach_line30", pos, 30 * HT);
    rst = 1;
    step();
    check("midrst_hs_b", b_hs, 1);
    check("midrst_vs_b", b_vs, 1);
    step();
    rst = 0;
    step();
    check("midrst_fs", a_fs, 1);
    check("midrst_vs_b_low", b_vs, 0);
    for (int i = 0; i < 200; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
